// File: rtl/fifo1to16_pkg.sv
// Shared constants and helpers for the narrow-to-wide packing FIFO.
package fifo1to16_pkg;
    localparam int BEATS = 16;
    localparam int CBITS = 4;

    // One-hot lane select for the beat index.
    function automatic logic [BEATS-1:0] lane_sel(input logic [CBITS-1:0] idx);
        lane_sel = {{(BEATS-1){1'b0}}, 1'b1} << idx;
    endfunction
endpackage

// File: rtl/fifo1to16_sync_fifo.sv
// First-word-fall-through FIFO with a registered head word and occupancy output.
module fifo1to16_sync_fifo #(
    parameter int DW    = 37,
    parameter int ABITS = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [DW-1:0]    wdata,
    input  logic             pop,
    output logic [DW-1:0]    rdata,
    output logic             valid,
    output logic [ABITS:0]   level,
    output logic             full_next
);
    localparam int DEPTH = 1 << ABITS;

    logic [DW-1:0]  mem_r [DEPTH];
    logic [DW-1:0]  rdata_r;
    logic [DW-1:0]  head_s;
    logic [ABITS:0] wr_ptr_r;
    logic [ABITS:0] rd_ptr_r;
    logic [ABITS:0] wr_next_s;
    logic [ABITS:0] rd_next_s;
    logic [ABITS:0] level_next_s;
    logic           valid_s;
    logic           pop_s;

    // Next pointers, next head word and next-cycle full flag.
    always_comb begin
        valid_s      = (wr_ptr_r != rd_ptr_r);
        pop_s        = pop & valid_s;
        wr_next_s    = wr_ptr_r + {{ABITS{1'b0}}, push};
        rd_next_s    = rd_ptr_r + {{ABITS{1'b0}}, pop_s};
        level_next_s = wr_next_s - rd_next_s;
        full_next    = (wr_next_s[ABITS] != rd_next_s[ABITS]) &&
                       (wr_next_s[ABITS-1:0] == rd_next_s[ABITS-1:0]);
        // The word being written this cycle becomes head when it lands at the read slot.
        if (rd_next_s == wr_ptr_r) begin
            head_s = wdata;
        end else begin
            head_s = mem_r[rd_next_s[ABITS-1:0]];
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[wr_ptr_r[ABITS-1:0]] <= wdata;
        end
    end

    // Pointers and registered head word; head holds its value once empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {(ABITS+1){1'b0}};
            rd_ptr_r <= {(ABITS+1){1'b0}};
            rdata_r  <= {DW{1'b0}};
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            if (level_next_s != {(ABITS+1){1'b0}}) begin
                rdata_r <= head_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign rdata = rdata_r;
    assign valid = valid_s;
    assign level = wr_ptr_r - rd_ptr_r;
endmodule

// File: rtl/fifo1to16.sv
// Packs narrow beats into 16-lane words (zero-padded on short frames) and queues them.
module fifo1to16
    import fifo1to16_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int ABITS = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   last_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o,
    output logic [CBITS-1:0]       count_o,
    output logic [WIDTH*BEATS-1:0] data_o,
    output logic [ABITS:0]         level_o
);
    localparam int WW = WIDTH * BEATS;

    logic [CBITS-1:0] index_r;
    logic [WW-1:0]    data_r;
    logic [WW-1:0]    packed_s;
    logic [BEATS-1:0] lane_en_s;
    logic             ready_r;
    logic             accept_s;
    logic             commit_s;
    logic             full_next_s;

    // Lane decode: merge the incoming beat into the partially built word.
    always_comb begin
        accept_s  = valid_i & ready_r;
        commit_s  = accept_s & ((index_r == 4'd15) | last_i);
        lane_en_s = lane_sel(index_r);
        packed_s  = data_r;
        for (int k = 0; k < BEATS; k++) begin
            if (lane_en_s[k]) begin
                packed_s[k*WIDTH +: WIDTH] = data_i;
            end else begin
                packed_s[k*WIDTH +: WIDTH] = data_r[k*WIDTH +: WIDTH];
            end
        end
    end

    // Packer index/shift state and registered input-side ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index_r <= 4'd0;
            data_r  <= {WW{1'b0}};
            ready_r <= 1'b0;
        end else begin
            ready_r <= ~full_next_s;
            if (commit_s) begin
                // Cleared shift data keeps unused upper lanes zero in short words.
                index_r <= 4'd0;
                data_r  <= {WW{1'b0}};
            end else if (accept_s) begin
                index_r <= index_r + 4'd1;
                data_r  <= packed_s;
            end else begin
                index_r <= index_r;
                data_r  <= data_r;
            end
        end
    end

    fifo1to16_sync_fifo #(
        .DW    (WW + CBITS + 1),
        .ABITS (ABITS)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (commit_s),
        .wdata     ({last_i, index_r, packed_s}),
        .pop       (ready_i),
        .rdata     ({last_o, count_o, data_o}),
        .valid     (valid_o),
        .level     (level_o),
        .full_next (full_next_s)
    );

    assign ready_o = ready_r;
endmodule
